// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the fetch/data memory-port arbiter.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_I = 2'd1,
        ARB_WAIT_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (I) and load/store (D): data-first with
// a fetch anti-starvation streak limit and a wait-lock that holds the port until handshake.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = ARB_ADDR_W,
    parameter int DATA_WIDTH  = ARB_DATA_W,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid_i,
    output logic                  i_ready_o,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic [DATA_WIDTH-1:0] i_wdata_i,
    input  logic [3:0]            i_we_i,
    output logic [DATA_WIDTH-1:0] i_rdata_o,
    input  logic                  d_valid_i,
    output logic                  d_ready_o,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    input  logic [3:0]            d_we_i,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  grant_d_o
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    arb_state_t state, state_next;
    owner_t     owner;
    logic [3:0] streak, streak_next;
    logic       grant_d_q;
    logic       handshake;

    // Owner selection: a locked owner wins outright; otherwise D first unless
    // I has been passed over MAX_DSTREAK times in a row.
    always_comb begin
        owner = OWN_NONE;
        unique case (state)
            ARB_WAIT_I: owner = OWN_I;
            ARB_WAIT_D: owner = OWN_D;
            default: begin
                if (d_valid_i && (!i_valid_i || (streak < STREAK_MAX)))
                    owner = OWN_D;
                else if (i_valid_i)
                    owner = OWN_I;
            end
        endcase
    end

    always_comb begin
        mem_valid_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = '0;
        i_ready_o   = 1'b0;
        d_ready_o   = 1'b0;
        unique case (owner)
            OWN_I: begin
                mem_valid_o = i_valid_i && !rst;
                mem_addr_o  = i_addr_i;
                mem_wdata_o = i_wdata_i;
                mem_we_o    = i_we_i;
                i_ready_o   = mem_ready_i && !rst;
            end
            OWN_D: begin
                mem_valid_o = d_valid_i && !rst;
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
                mem_we_o    = d_we_i;
                d_ready_o   = mem_ready_i && !rst;
            end
            default: ;
        endcase
    end

    assign i_rdata_o = mem_rdata_i;
    assign d_rdata_o = mem_rdata_i;
    assign handshake = mem_valid_o && mem_ready_i;

    // grant_d_o remembers the last owner across idle cycles.
    assign grant_d_o = (owner == OWN_D) || ((owner == OWN_NONE) && grant_d_q);

    always_comb begin
        state_next = state;
        unique case (state)
            ARB_WAIT_I: if (!i_valid_i || mem_ready_i) state_next = ARB_IDLE;
            ARB_WAIT_D: if (!d_valid_i || mem_ready_i) state_next = ARB_IDLE;
            default: begin
                if (owner == OWN_I && i_valid_i && !mem_ready_i)
                    state_next = ARB_WAIT_I;
                else if (owner == OWN_D && d_valid_i && !mem_ready_i)
                    state_next = ARB_WAIT_D;
            end
        endcase
    end

    always_comb begin
        streak_next = streak;
        if (!i_valid_i)
            streak_next = '0;
        else if (handshake && owner == OWN_I)
            streak_next = '0;
        else if (handshake && owner == OWN_D && streak < STREAK_MAX)
            streak_next = streak + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            streak    <= '0;
            grant_d_q <= 1'b0;
        end else begin
            state     <= state_next;
            streak    <= streak_next;
            grant_d_q <= grant_d_o;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter with a queue of expected per-cycle outputs.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic          iv;
        logic [AW-1:0] ia;
        logic          dv;
        logic [AW-1:0] da;
        logic [3:0]    dwe;
        logic          mr;
        logic          ev;
        logic          eir;
        logic          edr;
        logic          eg;
        int            own;   // 0 none, 1 I, 2 D
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid_i = 1'b0, d_valid_i = 1'b0, mem_ready_i = 1'b0;
    logic [AW-1:0] i_addr_i = '0, d_addr_i = '0, mem_addr_o;
    logic [DW-1:0] i_wdata_i = '0, d_wdata_i = '0, mem_wdata_o, mem_rdata_i = '0;
    logic [DW-1:0] i_rdata_o, d_rdata_o;
    logic [3:0]    i_we_i = '0, d_we_i = '0, mem_we_o;
    logic          i_ready_o, d_ready_o, mem_valid_o, grant_d_o;

    int checks = 0;
    int errors = 0;
    vec_t table_q[$];
    vec_t exp_q[$];

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DSTREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_valid_i(i_valid_i), .i_ready_o(i_ready_o), .i_addr_i(i_addr_i),
        .i_wdata_i(i_wdata_i), .i_we_i(i_we_i), .i_rdata_o(i_rdata_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_we_i(d_we_i), .d_rdata_o(d_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
        .grant_d_o(grant_d_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [AW-1:0] ia, input logic dv,
                                input logic [AW-1:0] da, input logic [3:0] dwe, input logic mr,
                                input logic ev, input logic eir, input logic edr,
                                input logic eg, input int own);
        vec_t v;
        v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dwe = dwe; v.mr = mr;
        v.ev = ev; v.eir = eir; v.edr = edr; v.eg = eg; v.own = own;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        logic [DW-1:0] rd;
        rd          = $urandom;
        i_valid_i   = v.iv;
        i_addr_i    = v.ia;
        d_valid_i   = v.dv;
        d_addr_i    = v.da;
        d_wdata_i   = ~v.da;
        d_we_i      = v.dwe;
        mem_ready_i = v.mr;
        mem_rdata_i = rd;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, " mem_valid"}, 32'(mem_valid_o), 32'(e.ev));
        chk({tag, " i_ready"},   32'(i_ready_o),   32'(e.eir));
        chk({tag, " d_ready"},   32'(d_ready_o),   32'(e.edr));
        chk({tag, " grant_d"},   32'(grant_d_o),   32'(e.eg));
        chk({tag, " mem_addr"},  mem_addr_o,  (e.own == 1) ? e.ia : (e.own == 2) ? e.da : '0);
        chk({tag, " mem_we"},    32'(mem_we_o), (e.own == 2) ? 32'(e.dwe) : 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata_o, (e.own == 2) ? ~e.da : '0);
        chk({tag, " rdata"},     i_rdata_o ^ d_rdata_o ^ rd, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Streak: D x4, I, D x4, I
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9)
                table_q.push_back(mk(1, 32'h100, 1, 32'h800, 4'h0, 1, 1, 1, 0, 0, 1));
            else
                table_q.push_back(mk(1, 32'h100, 1, 32'h800, 4'h0, 1, 1, 0, 1, 1, 2));
        end
        table_q.push_back(mk(0, 32'h0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0, 0));
        // Lone fetch, zero latency
        table_q.push_back(mk(1, 32'h100, 0, 32'h0, 4'h0, 1, 1, 1, 0, 0, 1));
        // Fetch wait-lock while D arrives
        table_q.push_back(mk(1, 32'h300, 0, 32'h0,   4'h0, 0, 1, 0, 0, 0, 1));
        table_q.push_back(mk(1, 32'h300, 1, 32'h804, 4'h0, 0, 1, 0, 0, 0, 1));
        table_q.push_back(mk(1, 32'h300, 1, 32'h804, 4'h0, 0, 1, 0, 0, 0, 1));
        table_q.push_back(mk(1, 32'h300, 1, 32'h804, 4'h0, 1, 1, 1, 0, 0, 1));
        table_q.push_back(mk(0, 32'h0,   1, 32'h804, 4'h0, 1, 1, 0, 1, 1, 2));
        // Fetch redirect while waiting
        table_q.push_back(mk(1, 32'h200, 0, 32'h0, 4'h0, 0, 1, 0, 0, 0, 1));
        table_q.push_back(mk(1, 32'h200, 0, 32'h0, 4'h0, 0, 1, 0, 0, 0, 1));
        table_q.push_back(mk(1, 32'h400, 0, 32'h0, 4'h0, 0, 1, 0, 0, 0, 1));
        table_q.push_back(mk(1, 32'h400, 0, 32'h0, 4'h0, 1, 1, 1, 0, 0, 1));
        // Store withdrawn while waiting; next cycle is back in IDLE so I wins
        table_q.push_back(mk(0, 32'h0,   1, 32'h900, 4'hF, 0, 1, 0, 0, 1, 2));
        table_q.push_back(mk(0, 32'h0,   1, 32'h900, 4'hF, 0, 1, 0, 0, 1, 2));
        table_q.push_back(mk(0, 32'h0,   0, 32'h900, 4'hF, 0, 0, 0, 0, 1, 2));
        table_q.push_back(mk(1, 32'h100, 0, 32'h0,   4'h0, 1, 1, 1, 0, 0, 1));

        // Reset state with requests and ready pending
        d_valid_i = 1'b1; i_valid_i = 1'b1; mem_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset mem_valid", 32'(mem_valid_o), 32'd0);
        chk("reset i_ready",   32'(i_ready_o),   32'd0);
        chk("reset d_ready",   32'(d_ready_o),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int n = 0; n < table_q.size(); n++)
            apply(table_q[n], $sformatf("vec%0d", n));

        // Build streak to 3, enter WAIT_D, then reset asynchronously mid-cycle
        for (int k = 0; k < 3; k++)
            apply(mk(1, 32'h100, 1, 32'h808, 4'h0, 1, 1, 0, 1, 1, 2), $sformatf("pre%0d", k));
        apply(mk(1, 32'h100, 1, 32'h808, 4'h0, 0, 1, 0, 0, 1, 2), "prewait");
        mem_ready_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async mem_valid", 32'(mem_valid_o), 32'd0);
        chk("async i_ready",   32'(i_ready_o),   32'd0);
        chk("async d_ready",   32'(d_ready_o),   32'd0);
        i_valid_i = 1'b0; d_valid_i = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        apply(mk(0, 32'h0, 0, 32'h0, 4'h0, 1, 0, 0, 0, 0, 0), "post idle");
        for (int k = 0; k < 4; k++)
            apply(mk(1, 32'h100, 1, 32'h80C, 4'h0, 1, 1, 0, 1, 1, 2), $sformatf("post d%0d", k));
        apply(mk(1, 32'h100, 1, 32'h80C, 4'h0, 1, 1, 1, 0, 0, 1), "post i");

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory between the fetch stage (instruction requester, I) and the load/store unit (data requester, D).
- Data has priority by default. A streak counter guarantees fetch a grant after MAX_DSTREAK back-to-back data grants.
- A wait-lock holds the grant on the current owner until its handshake completes or it withdraws.
- Sits between fetch_stage/LSU and the memory, using the same valid/ready, addr/wdata/we/rdata protocol on every side.

Parameters:
ADDR_WIDTH, 32, address width (matches `RISCV_ADDR_WIDTH)
DATA_WIDTH, 32, data width (matches `RISCV_WORD_WIDTH)
MAX_DSTREAK, 4, consecutive D grants allowed while I is pending; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
i_valid_i  input  1  fetch request valid
i_ready_o  output  1  fetch handshake completes this cycle
i_addr_i  input  ADDR_WIDTH  fetch address (may depend combinationally on i_ready_o)
i_wdata_i  input  DATA_WIDTH  fetch write data (normally 0)
i_we_i  input  4  fetch byte write enables (normally 0)
i_rdata_o  output  DATA_WIDTH  read data to fetch, valid when i_ready_o=1
d_valid_i  input  1  data request valid
d_ready_o  output  1  data handshake completes this cycle
d_addr_i  input  ADDR_WIDTH  data address
d_wdata_i  input  DATA_WIDTH  store data
d_we_i  input  4  byte write enables; 0 means load
d_rdata_o  output  DATA_WIDTH  load data, valid when d_ready_o=1
mem_valid_o  output  1  request to memory
mem_ready_i  input  1  memory accepts/completes request this cycle
mem_addr_o  output  ADDR_WIDTH  muxed address
mem_wdata_o  output  DATA_WIDTH  muxed write data
mem_we_o  output  4  muxed byte enables
mem_rdata_i  input  DATA_WIDTH  memory read data, valid with mem_ready_i
grant_d_o  output  1  1 while D owns the port, 0 while I owns it (debug/perf)

Behaviour:
- Handshake: a transfer completes in a cycle with mem_valid_o & mem_ready_i. rdata arrives in that same cycle.
- mem_ready_i must not depend combinationally on mem_addr_o, mem_wdata_o or mem_we_o. This breaks the loop mem_ready_i -> i_ready_o -> i_addr_i -> mem_addr_o.
- State machine, 2-bit register: ARB_IDLE, ARB_WAIT_I, ARB_WAIT_D. Reset state is ARB_IDLE.
- Owner selection, combinational:
  - WAIT_I selects I; WAIT_D selects D.
  - IDLE selects D if d_valid_i & (!i_valid_i | streak < MAX_DSTREAK).
  - Otherwise IDLE selects I if i_valid_i; else no owner.
- Datapath:
  - mem_valid_o = owner's valid & !rst.
  - mem_addr_o, mem_wdata_o, mem_we_o come from the owner.
  - With no owner: mem_addr_o, mem_wdata_o, mem_we_o are 0.
  - Owner's ready = mem_ready_i; the non-owner's ready = 0.
  - i_rdata_o = d_rdata_o = mem_rdata_i (broadcast).
- Transitions:
  - IDLE: owner X valid & !mem_ready_i -> WAIT_X. A handshake, or no owner, stays in IDLE.
  - WAIT_X: handshake -> IDLE. X_valid_i dropped (withdrawn, e.g. fetch redirect) -> IDLE with mem_valid_o=0 that cycle; no re-arbitration in the same cycle. Otherwise stay in WAIT_X.
  - The owner may change its address/data while waiting; the arbiter forwards the new values and keeps the lock.
- Streak counter (4-bit):
  - D handshake with i_valid_i=1: increment, saturating at MAX_DSTREAK.
  - I handshake: clear to 0.
  - Any cycle with i_valid_i=0: clear to 0.
  - Reset value is 0.
- grant_d_o = 1 when the owner is D; it holds its previous value when there is no owner. Reset value is 0.
- Reset outputs: mem_valid_o=0, i_ready_o=0, d_ready_o=0, state=ARB_IDLE, streak=0.
- Reset asserted mid-wait abandons the transaction. mem_valid_o drops combinationally with rst.
- Latency: zero added cycles. A request with mem_ready_i=1 completes in the same cycle it is raised.

Decomposition:
- Add the state encodings ARB_IDLE=2'd0, ARB_WAIT_I=2'd1, ARB_WAIT_D=2'd2 to a shared arbiter_defines.v, included next to riscv_defines.v.
- Widths come from `RISCV_ADDR_WIDTH and `RISCV_WORD_WIDTH.
- No sub-module: the streak counter and muxes stay inline. The block stays in a single file.

Test Plan:
- Both valid, mem_ready_i=1 every cycle, MAX_DSTREAK=4 -> D granted cycles 0-3, I in cycle 4, D cycles 5-8, I in cycle 9; streak resets after each I grant.
- Only I valid, addr 0x100, mem_ready_i=1 -> i_ready_o=1 in the same cycle, mem_addr_o=0x100, i_rdata_o=mem_rdata_i, grant_d_o=0.
- I granted, mem_ready_i=0 for 3 cycles, then D raises d_valid_i at cycle 1 -> WAIT_I held; d_ready_o=0 until the I handshake at cycle 3, then D is granted in cycle 4.
- I waiting at 0x200, i_addr_i changes to 0x400 at cycle 2 (redirect) -> mem_addr_o=0x400 from cycle 2; the handshake completes with addr 0x400.
- D waiting (store, we=4'hF), d_valid_i drops at cycle 2 -> mem_valid_o=0 in cycle 2, state IDLE in cycle 3, no write completes.
- rst pulsed high mid WAIT_D, asynchronously between edges -> mem_valid_o=0 and ready outputs 0 immediately; after release, state=ARB_IDLE and streak=0.
